cpu_ready_controller: RTL

CPU_READY_CONTROLLER -- requirements
Module: cpu_ready_controller

---
 rtl/cpu_ready_controller.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cpu_ready_controller.sv
// cpu_ready_controller
// Generates the registered READY to the CPU. It inserts a minimum number of
// wait clocks per bus cycle type, then extends the wait while the expansion
// bus or the DMA handover holds the cycle off. A timeout forces release.
// wait_state_count reports the length of the last completed cycle.
module cpu_ready_controller #(
    parameter int IO_WAIT_STATES  = 1,
    parameter int MEM_WAIT_STATES = 0,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       address_enable_n,
    input  logic       io_read_n,
    input  logic       io_write_n,
    input  logic       memory_read_n,
    input  logic       memory_write_n,
    input  logic       interrupt_acknowledge_n,
    input  logic       io_channel_ready,
    input  logic       dma_wait_n,
    output logic       cpu_ready,
    output logic       bus_timeout,
    output logic [7:0] wait_state_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The down-counter is preloaded with N-1: the IDLE->WAIT edge itself
    // already accounts for the first low clock.
    localparam logic [7:0] IO_DN  = (IO_WAIT_STATES  > 256) ? 8'hFF :
                                    (IO_WAIT_STATES  > 0)   ? 8'(IO_WAIT_STATES - 1)  : 8'd0;
    localparam logic [7:0] MEM_DN = (MEM_WAIT_STATES > 256) ? 8'hFF :
                                    (MEM_WAIT_STATES > 0)   ? 8'(MEM_WAIT_STATES - 1) : 8'd0;

    // The cycle counter saturates at 255, so cycle+1 never exceeds 256. A
    // larger timeout is clamped to 256 so a stuck cycle is still released.
    localparam logic [8:0] TO_LIM = (TIMEOUT_CYCLES > 256) ? 9'd256 :
                                    (TIMEOUT_CYCLES < 0)   ? 9'd0   : 9'(TIMEOUT_CYCLES);
    localparam logic [7:0] TO_WSC = (TIMEOUT_CYCLES > 255) ? 8'hFF :
                                    (TIMEOUT_CYCLES < 0)   ? 8'd0   : 8'(TIMEOUT_CYCLES);

    state_t     r_state;
    logic       r_sync1;
    logic       r_sync2;
    logic [7:0] r_down;
    logic [7:0] r_cycle;

    logic       w_cmd_io;
    logic       w_cmd_mem;
    logic       w_cmd_any;
    logic       w_release;
    logic       w_sel_zero;
    logic [7:0] w_sel_dn;
    logic [8:0] w_cycle_inc;
    logic [7:0] w_cycle_sat;
    logic       w_timeout;

    assign w_cmd_io   = ~address_enable_n &
                        (~io_read_n | ~io_write_n | ~interrupt_acknowledge_n);
    assign w_cmd_mem  = ~address_enable_n & (~memory_read_n | ~memory_write_n);
    assign w_cmd_any  = w_cmd_io | w_cmd_mem;
    assign w_release  = r_sync2 & dma_wait_n;

    // I/O (and INTA) take precedence when both command classes are active.
    assign w_sel_zero = w_cmd_io ? (IO_WAIT_STATES <= 0) : (MEM_WAIT_STATES <= 0);
    assign w_sel_dn   = w_cmd_io ? IO_DN : MEM_DN;

    // Count including the current edge, and its 8-bit saturated form.
    assign w_cycle_inc = {1'b0, r_cycle} + 9'd1;
    assign w_cycle_sat = (r_cycle == 8'hFF) ? 8'hFF : w_cycle_inc[7:0];
    assign w_timeout   = (w_cycle_inc >= TO_LIM);

    // Two-flop synchronizer for the asynchronous expansion-bus ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= io_channel_ready;
            r_sync2 <= r_sync1;
        end
    end

    // Bus-cycle FSM with registered READY, timeout pulse and wait count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_down           <= 8'd0;
            r_cycle          <= 8'd0;
            cpu_ready        <= 1'b1;
            bus_timeout      <= 1'b0;
            wait_state_count <= 8'd0;
        end else begin
            bus_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    cpu_ready <= 1'b1;
                    if (w_cmd_any) begin
                        if (w_sel_zero && w_release) begin
                            // Zero-wait cycle with the bus ready: never drop READY.
                            r_state          <= S_DONE;
                            wait_state_count <= 8'd0;
                        end else begin
                            r_state   <= S_WAIT;
                            cpu_ready <= 1'b0;
                            r_down    <= w_sel_dn;
                            r_cycle   <= 8'd0;
                        end
                    end
                end
                S_WAIT: begin
                    if (address_enable_n) begin
                        // DMA took the bus: abandon the cycle, keep the old count.
                        r_state   <= S_IDLE;
                        cpu_ready <= 1'b1;
                    end else if (w_timeout) begin
                        r_state          <= S_DONE;
                        cpu_ready        <= 1'b1;
                        bus_timeout      <= 1'b1;
                        wait_state_count <= TO_WSC;
                    end else if ((r_down == 8'd0) && w_release) begin
                        r_state          <= S_DONE;
                        cpu_ready        <= 1'b1;
                        wait_state_count <= w_cycle_sat;
                    end else begin
                        // Strobes going away here are ignored; keep counting.
                        r_cycle <= w_cycle_sat;
                        if (r_down != 8'd0) begin
                            r_down <= r_down - 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    // Hold until the strobes drop so one strobe is one cycle.
                    cpu_ready <= 1'b1;
                    if (!w_cmd_any) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    cpu_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
